// File: rtl/tomasulo_issue_unit.sv
// In-order issue stage: classifies one decoded instruction per cycle, allocates ROB tag + RS slot, renames operands.
// Latency: fire in cycle N -> iss_valid and all iss_* fields in cycle N+1 (one-cycle pulse).
// Backpressure: in_ready drops while flushing, when the ROB is full, or when the target RS class is full; no full-bypass.
module tomasulo_issue_unit #(
  parameter int ROB_DEPTH    = 8,
  parameter int RS_PER_CLASS = 3,
  parameter int NREG         = 16,
  parameter int TAG_W        = $clog2(ROB_DEPTH),
  parameter int CNT_W        = $clog2(RS_PER_CLASS + 1)
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_func,
  input  logic [3:0]       in_rs1,
  input  logic [3:0]       in_rs2,
  input  logic [3:0]       in_rd,
  input  logic [7:0]       in_addr,
  output logic             iss_valid,
  output logic [2:0]       iss_class,
  output logic [TAG_W-1:0] iss_tag,
  output logic [3:0]       iss_func,
  output logic [3:0]       iss_rd,
  output logic [7:0]       iss_addr,
  output logic             iss_rs1_busy,
  output logic             iss_rs2_busy,
  output logic [TAG_W-1:0] iss_rs1_tag,
  output logic [TAG_W-1:0] iss_rs2_tag,
  input  logic [2:0]       rs_free,
  input  logic             commit_valid,
  input  logic             flush,
  output logic [TAG_W:0]   rob_count,
  output logic [CNT_W-1:0] add_count,
  output logic [CNT_W-1:0] mul_count,
  output logic [CNT_W-1:0] bch_count,
  output logic             stall_rob,
  output logic             stall_rs
);

  localparam logic [TAG_W:0]   ROB_CAP = (TAG_W + 1)'(ROB_DEPTH);
  localparam logic [CNT_W-1:0] RS_CAP  = CNT_W'(RS_PER_CLASS);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [TAG_W:0]   head_q, tail_q;
  logic [3:0]       rob_rd [ROB_DEPTH];
  logic [NREG-1:0]  reg_busy;
  logic [TAG_W-1:0] reg_tag [NREG];
  logic [CNT_W-1:0] cnt_q [3];

  logic [2:0]       cls_oh;
  logic [CNT_W-1:0] cls_cnt;
  logic             rob_full, cls_full, fire, commit_en, commit_clr;
  logic [TAG_W-1:0] head_idx, tail_idx;
  logic [3:0]       commit_rd;
  logic             rs1_busy, rs2_busy;

  function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] cnt,
                                                input logic inc, input logic dec);
    logic [CNT_W-1:0] n;
    n = cnt;
    if (inc && !dec)
      n = cnt + 1'b1;
    else if (dec && !inc && cnt != '0)
      n = cnt - 1'b1;
    return n;
  endfunction

  always_comb begin
    cls_oh = 3'b100;
    if (!in_func[3])
      cls_oh = 3'b001;
    else if (!in_func[2])
      cls_oh = 3'b010;
  end

  assign cls_cnt   = cls_oh[0] ? cnt_q[0] : (cls_oh[1] ? cnt_q[1] : cnt_q[2]);
  assign rob_count = tail_q - head_q;
  assign rob_full  = (rob_count == ROB_CAP);
  assign cls_full  = (cls_cnt >= RS_CAP);
  assign in_ready  = !flush && !rob_full && !cls_full;
  assign fire      = in_valid && in_ready;
  assign stall_rob = in_valid && rob_full;
  assign stall_rs  = in_valid && !rob_full && cls_full;

  assign head_idx  = head_q[TAG_W-1:0];
  assign tail_idx  = tail_q[TAG_W-1:0];
  assign commit_en = commit_valid && (rob_count != '0);
  assign commit_rd = rob_rd[head_idx];
  // Only release the register if no younger producer has renamed it since.
  assign commit_clr = commit_en && reg_busy[commit_rd] && (reg_tag[commit_rd] == head_idx);

  // Lookups use pre-update state, with the same-cycle commit release bypassed in.
  assign rs1_busy = reg_busy[in_rs1] && !(commit_clr && in_rs1 == commit_rd);
  assign rs2_busy = reg_busy[in_rs2] && !(commit_clr && in_rs2 == commit_rd);

  assign add_count = cnt_q[0];
  assign mul_count = cnt_q[1];
  assign bch_count = cnt_q[2];

  always_ff @(posedge clk1) begin
    if (fire)
      rob_rd[tail_idx] <= in_rd;
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      head_q       <= '0;
      tail_q       <= '0;
      reg_busy     <= '0;
      for (int i = 0; i < NREG; i++) reg_tag[i] <= '0;
      for (int k = 0; k < 3; k++) cnt_q[k] <= '0;
      iss_valid    <= 1'b0;
      iss_class    <= '0;
      iss_tag      <= '0;
      iss_func     <= '0;
      iss_rd       <= '0;
      iss_addr     <= '0;
      iss_rs1_busy <= 1'b0;
      iss_rs2_busy <= 1'b0;
      iss_rs1_tag  <= '0;
      iss_rs2_tag  <= '0;
    end else if (flush) begin
      head_q       <= '0;
      tail_q       <= '0;
      reg_busy     <= '0;
      for (int k = 0; k < 3; k++) cnt_q[k] <= '0;
      iss_valid    <= 1'b0;
      iss_class    <= '0;
      iss_tag      <= '0;
      iss_func     <= '0;
      iss_rd       <= '0;
      iss_addr     <= '0;
      iss_rs1_busy <= 1'b0;
      iss_rs2_busy <= 1'b0;
      iss_rs1_tag  <= '0;
      iss_rs2_tag  <= '0;
    end else begin
      if (fire)
        tail_q <= tail_q + 1'b1;
      if (commit_en)
        head_q <= head_q + 1'b1;
      // A rename by this cycle's fire wins over the commit release.
      if (commit_clr && !(fire && in_rd == commit_rd))
        reg_busy[commit_rd] <= 1'b0;
      if (fire) begin
        reg_busy[in_rd] <= 1'b1;
        reg_tag[in_rd]  <= tail_idx;
      end
      for (int k = 0; k < 3; k++)
        cnt_q[k] <= next_cnt(cnt_q[k], fire && cls_oh[k], rs_free[k]);
      iss_valid    <= fire;
      iss_class    <= fire ? cls_oh : 3'b000;
      iss_tag      <= fire ? tail_idx : '0;
      iss_func     <= fire ? in_func : '0;
      iss_rd       <= fire ? in_rd : '0;
      iss_addr     <= fire ? in_addr : '0;
      iss_rs1_busy <= fire && rs1_busy;
      iss_rs2_busy <= fire && rs2_busy;
      iss_rs1_tag  <= (fire && rs1_busy) ? reg_tag[in_rs1] : '0;
      iss_rs2_tag  <= (fire && rs2_busy) ? reg_tag[in_rs2] : '0;
    end
  end

endmodule
